// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI command codes and target state encoding
package spi_pkg;

   localparam logic [7:0] SPI_CMD_READ  = 8'h03;
   localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR_HI,
      ADDR_LO,
      RD_DATA,
      WR_DATA,
      IGNORE
   } spi_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - two-flop synchronizers and SCK edge detect for the SPI target pins
module spi_pin_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic spi_cs_n,
   input  logic spi_clk,
   input  logic spi_mosi,
   output logic cs_s,
   output logic mosi_s,
   output logic sck_rise,
   output logic sck_fall
);

   logic cs_m_q, cs_m_d, cs_s_q, cs_s_d;
   logic sck_m_q, sck_m_d, sck_s_q, sck_s_d, sck_dly_q, sck_dly_d;
   logic mosi_m_q, mosi_m_d, mosi_s_q, mosi_s_d;

   always_comb begin
      cs_m_d    = spi_cs_n;
      cs_s_d    = cs_m_q;
      sck_m_d   = spi_clk;
      sck_s_d   = sck_m_q;
      sck_dly_d = sck_s_q;
      mosi_m_d  = spi_mosi;
      mosi_s_d  = mosi_m_q;
   end

   // Reset to idle pin levels so no edge or select is seen coming out of reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cs_m_q    <= 1'b1;
         cs_s_q    <= 1'b1;
         sck_m_q   <= 1'b0;
         sck_s_q   <= 1'b0;
         sck_dly_q <= 1'b0;
         mosi_m_q  <= 1'b0;
         mosi_s_q  <= 1'b0;
      end else begin
         cs_m_q    <= cs_m_d;
         cs_s_q    <= cs_s_d;
         sck_m_q   <= sck_m_d;
         sck_s_q   <= sck_s_d;
         sck_dly_q <= sck_dly_d;
         mosi_m_q  <= mosi_m_d;
         mosi_s_q  <= mosi_s_d;
      end
   end

   assign cs_s     = cs_s_q;
   assign mosi_s   = mosi_s_q;
   assign sck_rise = sck_s_q & ~sck_dly_q;
   assign sck_fall = ~sck_s_q & sck_dly_q;

endmodule

// File: rtl/spi_sram_target.sv
// rtl/spi_sram_target.sv - SPI mode-0 target emulating a byte-addressed serial SRAM
module spi_sram_target
   import spi_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic spi_cs_n,
   input  logic spi_clk,
   input  logic spi_mosi,
   output logic spi_miso,
   output logic spi_miso_oe,
   output logic busy,
   output logic cmd_err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] IDX_ONE = AW'(1);

   logic cs_s, mosi_s, sck_rise, sck_fall;
   spi_state_e state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [15:0] addr_q, addr_d, ld_addr;
   logic [6:0] rx_q, rx_d;
   logic [7:0] rx_byte, tx_q, tx_d;
   logic is_rd_q, is_rd_d;
   logic miso_q, miso_d, miso_oe_q, miso_oe_d;
   logic busy_q, busy_d, cmd_err_q, cmd_err_d;
   logic mem_we;
   logic [AW-1:0] idx_inc;
   logic addr_hi_unused;
   logic [7:0] mem [DEPTH];

   spi_pin_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .spi_cs_n (spi_cs_n),
      .spi_clk  (spi_clk),
      .spi_mosi (spi_mosi),
      .cs_s     (cs_s),
      .mosi_s   (mosi_s),
      .sck_rise (sck_rise),
      .sck_fall (sck_fall)
   );

   // Address bits above AW are kept only for byte framing; they never select storage.
   assign addr_hi_unused = ^(addr_q >> AW);

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      addr_d    = addr_q;
      rx_d      = rx_q;
      tx_d      = tx_q;
      is_rd_d   = is_rd_q;
      miso_d    = miso_q;
      cmd_err_d = cmd_err_q;
      mem_we    = 1'b0;
      rx_byte   = {rx_q, mosi_s};
      ld_addr   = {addr_q[15:8], rx_byte};
      idx_inc   = addr_q[AW-1:0] + IDX_ONE;
      miso_oe_d = ~cs_s;
      if (cs_s) begin
         state_d   = IDLE;
         bit_cnt_d = 3'd0;
         miso_d    = 1'b0;
      end else if (state_q == IDLE) begin
         state_d = CMD;
      end else if (sck_rise) begin
         rx_d      = rx_byte[6:0];
         bit_cnt_d = bit_cnt_q + 3'd1;
         if (bit_cnt_q == 3'd7) begin
            case (state_q)
               CMD: begin
                  if (rx_byte == SPI_CMD_READ) begin
                     is_rd_d = 1'b1;
                     state_d = ADDR_HI;
                  end else if (rx_byte == SPI_CMD_WRITE) begin
                     is_rd_d = 1'b0;
                     state_d = ADDR_HI;
                  end else begin
                     state_d   = IGNORE;
                     cmd_err_d = 1'b1;
                  end
               end
               ADDR_HI: begin
                  addr_d[15:8] = rx_byte;
                  state_d      = ADDR_LO;
               end
               ADDR_LO: begin
                  addr_d  = ld_addr;
                  tx_d    = mem[ld_addr[AW-1:0]];
                  state_d = is_rd_q ? RD_DATA : WR_DATA;
               end
               RD_DATA: begin
                  addr_d = 16'(idx_inc);
                  tx_d   = mem[idx_inc];
               end
               WR_DATA: begin
                  mem_we = 1'b1;
                  addr_d = 16'(idx_inc);
               end
               default: ;
            endcase
         end
      end else if (sck_fall && state_q == RD_DATA) begin
         // The first fall after a load presents the fresh MSB; later falls shift.
         if (bit_cnt_q == 3'd0) begin
            miso_d = tx_q[7];
         end else begin
            tx_d   = {tx_q[6:0], 1'b0};
            miso_d = tx_q[6];
         end
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         bit_cnt_q <= 3'd0;
         addr_q    <= 16'd0;
         rx_q      <= 7'd0;
         tx_q      <= 8'd0;
         is_rd_q   <= 1'b0;
         miso_q    <= 1'b0;
         miso_oe_q <= 1'b0;
         busy_q    <= 1'b0;
         cmd_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         addr_q    <= addr_d;
         rx_q      <= rx_d;
         tx_q      <= tx_d;
         is_rd_q   <= is_rd_d;
         miso_q    <= miso_d;
         miso_oe_q <= miso_oe_d;
         busy_q    <= busy_d;
         cmd_err_q <= cmd_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && mem_we) begin
         mem[addr_q[AW-1:0]] <= rx_byte;
      end
   end

   assign spi_miso    = miso_q;
   assign spi_miso_oe = miso_oe_q;
   assign busy        = busy_q;
   assign cmd_err     = cmd_err_q;

endmodule
